// File: rtl/basic_pkg.sv
// Definitions shared by the basic-computer memory, its master and the control unit.
package basic_pkg;

   localparam int ADDR_W = 12;
   localparam int DATA_W = 16;
   localparam int CNT_W  = 4;
   localparam int CNT_MAX = (1 << CNT_W) - 1;

   typedef enum logic [2:0] {IDLE, SETUP, RD, WR, HOLD, RESP} mem_state_t;

   // The counter runs down to zero inclusive, so an N-cycle strobe loads N-1.
   function automatic logic [CNT_W-1:0] cnt_load(input int cycles);
      return CNT_W'(cycles - 1);
   endfunction

endpackage

// File: rtl/mem_master_if.sv
// Request/response handshake plus memory command bus seen by mem_master.
interface mem_master_if #(
   parameter int ADDR_W = basic_pkg::ADDR_W,
   parameter int DATA_W = basic_pkg::DATA_W
);
   logic              req_valid;
   logic              req_ready;
   logic              req_write;
   logic [ADDR_W-1:0] req_addr;
   logic [DATA_W-1:0] req_wdata;
   logic              rsp_valid;
   logic [DATA_W-1:0] rsp_rdata;
   logic [ADDR_W-1:0] mem_adress;
   logic              mem_read;
   logic              mem_write;
   logic [DATA_W-1:0] mem_indata;
   logic [DATA_W-1:0] mem_outdata;

   modport master (
      input  req_valid, req_write, req_addr, req_wdata, mem_outdata,
      output req_ready, rsp_valid, rsp_rdata,
      output mem_adress, mem_read, mem_write, mem_indata
   );

   modport slave (
      output req_valid, req_write, req_addr, req_wdata, mem_outdata,
      input  req_ready, rsp_valid, rsp_rdata,
      input  mem_adress, mem_read, mem_write, mem_indata
   );
endinterface

// File: rtl/mem_wait_cnt.sv
// Loadable down-counter that paces how long mem_read / mem_write stay asserted.
module mem_wait_cnt
   import basic_pkg::*;
(
   input  logic             clk,
   input  logic             rst_n,
   input  logic             load,
   input  logic [CNT_W-1:0] load_val,
   input  logic             dec,
   output logic             zero
);
   logic [CNT_W-1:0] value_reg;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         value_reg <= '0;
      end else if (load) begin
         value_reg <= load_val;
      end else if (dec && value_reg != '0) begin
         value_reg <= value_reg - CNT_W'(1);
      end
   end

   assign zero = (value_reg == '0);

endmodule

// File: rtl/mem_master.sv
// CPU-side initiator: turns single valid/ready requests into timed read/write
// cycles on the basic-computer memory, with address setup and hold.
module mem_master #(
   parameter int ADDR_W    = basic_pkg::ADDR_W,
   parameter int DATA_W    = basic_pkg::DATA_W,
   parameter int RD_WAIT   = 1,
   parameter int WR_CYCLES = 1
) (
   input  logic         clk,
   input  logic         rst_n,
   mem_master_if.master bus
);
   import basic_pkg::*;

   if (RD_WAIT < 1 || RD_WAIT > CNT_MAX) begin : g_bad_rd_wait
      $error("mem_master: RD_WAIT out of range 1..15");
   end
   if (WR_CYCLES < 1 || WR_CYCLES > CNT_MAX) begin : g_bad_wr_cycles
      $error("mem_master: WR_CYCLES out of range 1..15");
   end

   localparam logic [CNT_W-1:0] RD_LOAD = cnt_load(RD_WAIT);
   localparam logic [CNT_W-1:0] WR_LOAD = cnt_load(WR_CYCLES);

   mem_state_t        state_reg, state_next;
   logic [ADDR_W-1:0] adress_reg;
   logic [DATA_W-1:0] indata_reg;
   logic [DATA_W-1:0] rdata_reg;
   logic              write_reg;

   logic              accept;
   logic              capture;
   logic              cnt_load_en;
   logic [CNT_W-1:0]  cnt_load_val;
   logic              cnt_dec;
   logic              cnt_zero;

   mem_wait_cnt u_wait_cnt (
      .clk      (clk),
      .rst_n    (rst_n),
      .load     (cnt_load_en),
      .load_val (cnt_load_val),
      .dec      (cnt_dec),
      .zero     (cnt_zero)
   );

   always_comb begin
      state_next   = state_reg;
      accept       = 1'b0;
      capture      = 1'b0;
      cnt_load_en  = 1'b0;
      cnt_load_val = '0;
      cnt_dec      = 1'b0;
      case (state_reg)
         IDLE: begin
            if (bus.req_valid) begin
               accept     = 1'b1;
               state_next = SETUP;
            end
         end
         SETUP: begin
            cnt_load_en  = 1'b1;
            cnt_load_val = write_reg ? WR_LOAD : RD_LOAD;
            state_next   = write_reg ? WR : RD;
         end
         RD: begin
            if (cnt_zero) begin
               capture    = 1'b1;
               state_next = RESP;
            end else begin
               cnt_dec = 1'b1;
            end
         end
         WR: begin
            if (cnt_zero) begin
               state_next = HOLD;
            end else begin
               cnt_dec = 1'b1;
            end
         end
         HOLD:    state_next = RESP;
         RESP:    state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg  <= IDLE;
         adress_reg <= '0;
         indata_reg <= '0;
         write_reg  <= 1'b0;
         rdata_reg  <= '0;
      end else begin
         state_reg <= state_next;
         if (accept) begin
            adress_reg <= bus.req_addr;
            indata_reg <= bus.req_wdata;
            write_reg  <= bus.req_write;
         end
         if (capture) begin
            rdata_reg <= bus.mem_outdata;
         end
      end
   end

   // Ready is masked by rst_n so the control unit sees "busy" while held in reset.
   assign bus.req_ready  = rst_n && (state_reg == IDLE);
   assign bus.rsp_valid  = (state_reg == RESP);
   assign bus.rsp_rdata  = rdata_reg;
   assign bus.mem_adress = adress_reg;
   assign bus.mem_indata = indata_reg;
   assign bus.mem_read   = (state_reg == RD);
   assign bus.mem_write  = (state_reg == WR);

endmodule

// File: tb/tb_mem_master.sv
// Bench for mem_master: cycle-offset reference model checked every cycle,
// directed transactions with literal expectations, then a random mixed run.
module tb_mem_master;

   localparam int RD_WAIT   = 4;
   localparam int WR_CYCLES = 2;
   localparam int RD_LAT    = RD_WAIT + 2;
   localparam int WR_LAT    = WR_CYCLES + 3;

   logic clk = 1'b0;
   logic rst_n;

   int checks = 0;
   int errors = 0;

   mem_master_if #(.ADDR_W(12), .DATA_W(16)) bus ();

   mem_master #(
      .ADDR_W    (12),
      .DATA_W    (16),
      .RD_WAIT   (RD_WAIT),
      .WR_CYCLES (WR_CYCLES)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus.master)
   );

   always #5 clk = ~clk;

   // Memory the DUT talks to.
   logic [15:0] mem [4096];
   assign bus.mem_outdata = mem[bus.mem_adress];
   always @(posedge clk) begin
      if (bus.mem_write) mem[bus.mem_adress] <= bus.mem_indata;
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s t=%0t actual=%0h expected=%0h", name, $time, act, exp);
      end
   endtask

   // Reference model: tracks the cycle offset k since the accepting edge.
   logic [15:0] sb [4096];
   bit          m_busy = 0;
   int          m_k = 0;
   bit          m_write = 0;
   logic [11:0] m_addr = '0;
   logic [11:0] m_adr = '0;
   logic [15:0] m_ind = '0;
   logic [15:0] m_rdata = '0;
   bit          m_acc = 0;
   logic [11:0] prev_adr = '0;

   initial begin
      int len;
      bit e_ready, e_rd, e_wr, e_rsp;
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            m_busy = 0; m_k = 0; m_adr = '0; m_ind = '0; m_rdata = '0; m_acc = 0;
            prev_adr = bus.mem_adress;
         end
         len     = m_write ? WR_LAT : RD_LAT;
         e_ready = rst_n && !m_busy;
         e_rd    = m_busy && !m_write && m_k >= 2 && m_k <= RD_WAIT + 1;
         e_wr    = m_busy &&  m_write && m_k >= 2 && m_k <= WR_CYCLES + 1;
         e_rsp   = m_busy && m_k == len;
         chk("req_ready",  32'(bus.req_ready),  32'(e_ready));
         chk("mem_read",   32'(bus.mem_read),   32'(e_rd));
         chk("mem_write",  32'(bus.mem_write),  32'(e_wr));
         chk("rsp_valid",  32'(bus.rsp_valid),  32'(e_rsp));
         chk("rsp_rdata",  32'(bus.rsp_rdata),  32'(m_rdata));
         chk("mem_adress", 32'(bus.mem_adress), 32'(m_adr));
         chk("mem_indata", 32'(bus.mem_indata), 32'(m_ind));
         chk("rd_wr_excl", 32'(bus.mem_read && bus.mem_write), 32'(0));
         if (rst_n) begin
            chk("adr_only_on_accept", 32'(bus.mem_adress != prev_adr && !m_acc), 32'(0));
            prev_adr = bus.mem_adress;
            m_acc = 0;
            if (!m_busy) begin
               if (bus.req_valid) begin
                  m_busy = 1; m_k = 1; m_acc = 1;
                  m_write = bus.req_write;
                  m_addr  = bus.req_addr;
                  m_adr   = bus.req_addr;
                  m_ind   = bus.req_wdata;
                  if (bus.req_write) sb[bus.req_addr] = bus.req_wdata;
               end
            end else if (m_k == len) begin
               m_busy = 0;
            end else begin
               m_k++;
               if (m_k == len && !m_write) m_rdata = sb[m_addr];
            end
         end
      end
   end

   // Returns just after the edge that accepted the pending request.
   task automatic wait_accept(output int n);
      bit got, r;
      got = 0; n = 0;
      for (int i = 0; i < 40 && !got; i++) begin
         @(negedge clk);
         r = bus.req_ready;
         @(posedge clk);
         n++;
         if (r) got = 1;
      end
      chk("accept_timeout", 32'(got), 32'(1));
   endtask

   task automatic do_req(input bit w, input logic [11:0] a, input logic [15:0] d,
                         output int lat, output logic [15:0] rd, output int wcnt);
      int n;
      bit done;
      @(posedge clk); #1;
      bus.req_valid = 1; bus.req_write = w; bus.req_addr = a; bus.req_wdata = d;
      wait_accept(n);
      #1 bus.req_valid = 0;
      lat = 0; wcnt = 0; done = 0; rd = '0;
      for (int i = 0; i < 40 && !done; i++) begin
         @(negedge clk);
         lat++;
         if (bus.mem_write) wcnt++;
         if (bus.rsp_valid) begin
            rd = bus.rsp_rdata;
            done = 1;
         end else begin
            chk("adr_setup_hold", 32'(bus.mem_adress), 32'(a));
         end
      end
      chk("rsp_timeout", 32'(done), 32'(1));
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog t=%0t", $time);
      $fatal(1, "watchdog expired");
   end

   initial begin
      int lat, wcnt, n;
      logic [15:0] rd;
      for (int i = 0; i < 4096; i++) begin
         mem[i] = '0;
         sb[i]  = '0;
      end
      bus.req_valid = 0; bus.req_write = 0; bus.req_addr = '0; bus.req_wdata = '0;
      rst_n = 1'b1;
      #1 rst_n = 1'b0;

      // Reset
      @(negedge clk);
      chk("rst_ready_low", 32'(bus.req_ready), 32'(0));
      chk("rst_adress",    32'(bus.mem_adress), 32'(0));
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      @(negedge clk);
      chk("rel_ready", 32'(bus.req_ready), 32'(1));
      chk("rel_read",  32'(bus.mem_read),  32'(0));
      chk("rel_write", 32'(bus.mem_write), 32'(0));

      // Write then read
      do_req(1, 12'h0A5, 16'h1234, lat, rd, wcnt);
      chk("wr_lat", 32'(lat), 32'(5));
      chk("wr_strobe_cycles", 32'(wcnt), 32'(2));
      do_req(0, 12'h0A5, 16'h0000, lat, rd, wcnt);
      chk("rd_lat", 32'(lat), 32'(6));
      chk("rd_data_0a5", 32'(rd), 32'(16'h1234));
      $display("read 0a5 latency %0d data %h", lat, rd);

      // Boundary values
      do_req(1, 12'hFFF, 16'hFFFF, lat, rd, wcnt);
      do_req(1, 12'h000, 16'h0000, lat, rd, wcnt);
      do_req(0, 12'hFFF, 16'h0000, lat, rd, wcnt);
      chk("rd_data_fff", 32'(rd), 32'(16'hFFFF));
      do_req(0, 12'h000, 16'hAAAA, lat, rd, wcnt);
      chk("rd_data_000", 32'(rd), 32'(16'h0000));
      do_req(0, 12'h0A5, 16'h0000, lat, rd, wcnt);

      // Back-to-back: read, then a write presented immediately
      @(posedge clk); #1;
      bus.req_valid = 1; bus.req_write = 0; bus.req_addr = 12'hFFF; bus.req_wdata = 16'h5555;
      wait_accept(n);
      #1 bus.req_write = 1; bus.req_addr = 12'h123;
      wait_accept(n);
      chk("b2b_accept_gap", 32'(n), 32'(7));
      chk("b2b_rdata_after_rd", 32'(bus.rsp_rdata), 32'(16'hFFFF));
      #1 bus.req_valid = 0;
      repeat (WR_LAT + 1) @(negedge clk);
      chk("b2b_rdata_after_wr", 32'(bus.rsp_rdata), 32'(16'hFFFF));
      $display("back-to-back accept gap %0d rdata %h", n, bus.rsp_rdata);

      // Reset during RD
      @(posedge clk); #1;
      bus.req_valid = 1; bus.req_write = 0; bus.req_addr = 12'h0A5;
      wait_accept(n);
      #1 bus.req_valid = 0;
      @(posedge clk); @(posedge clk); #2;
      chk("mid_rd_active", 32'(bus.mem_read), 32'(1));
      rst_n = 1'b0;
      #1;
      chk("mid_rst_read",  32'(bus.mem_read),  32'(0));
      chk("mid_rst_rsp",   32'(bus.rsp_valid), 32'(0));
      chk("mid_rst_ready", 32'(bus.req_ready), 32'(0));
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         chk("post_rst_no_rsp", 32'(bus.rsp_valid), 32'(0));
      end
      do_req(0, 12'h0A5, 16'h0000, lat, rd, wcnt);
      chk("post_rst_rd_data", 32'(rd), 32'(16'h1234));
      $display("after mid-read reset: read 0a5 data %h", rd);

      // Random mixed traffic, scored by the model
      for (int t = 0; t < 1000; t++) begin
         logic [11:0] a;
         bit w;
         w = ($urandom_range(0, 1) == 1);
         a = ($urandom_range(0, 9) == 0) ? 12'hFFF : 12'($urandom_range(0, 15));
         repeat ($urandom_range(0, 2)) @(posedge clk);
         do_req(w, a, 16'($urandom), lat, rd, wcnt);
         chk("rand_lat", 32'(lat), w ? 32'(WR_LAT) : 32'(RD_LAT));
         if (!w) chk("rand_rd_data", 32'(rd), 32'(sb[a]));
      end

      repeat (3) @(negedge clk);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/mem_master.md
Name: mem_master

Overview:
- CPU-side initiator for the 4096x16 basic-computer memory.
- Accepts single read/write requests from the control unit over a valid/ready handshake.
- Sequences the memory's adress/read/write/indata lines with address setup and hold, and never asserts read and write together.
- Returns read data through a one-cycle response strobe. Sits between the control unit (AR/DR path) and the memory block.

Parameters:
- ADDR_W, 12, memory address width.
- DATA_W, 16, memory word width.
- RD_WAIT, 1, cycles mem_read is held before mem_outdata is sampled. Legal range 1..15.
- WR_CYCLES, 1, cycles mem_write is held high. Legal range 1..15.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- req_valid  in  1  control unit presents a request.
- req_ready  out  1  block can accept a request.
- req_write  in  1  1 = write, 0 = read; qualified by req_valid.
- req_addr  in  ADDR_W  target word address.
- req_wdata  in  DATA_W  write data; ignored for reads.
- rsp_valid  out  1  one-cycle strobe: transaction complete.
- rsp_rdata  out  DATA_W  last read word; holds until the next read completes.
- mem_adress  out  ADDR_W  address to memory.
- mem_read  out  1  memory read command.
- mem_write  out  1  memory write command.
- mem_indata  out  DATA_W  write data to memory.
- mem_outdata  in  DATA_W  read data from memory.

Behaviour:
- Reset: one clock, clk; reset rst_n is asynchronous, active-low.
  - rst_n low forces state IDLE immediately.
  - Outputs: mem_read=0, mem_write=0, mem_adress=0, mem_indata=0, rsp_valid=0, rsp_rdata=0, req_ready=1 after release.
- Outputs are registered or decoded from the state register only. There is no combinational path from req_* to mem_*.
- States:
  - IDLE: req_ready=1. On req_valid&req_ready, latch req_addr, req_wdata and req_write into mem_adress, mem_indata and the op flag. Go to SETUP.
  - SETUP: one cycle. mem_adress is stable; mem_read=mem_write=0. Load the wait counter with RD_WAIT-1 or WR_CYCLES-1. Go to RD or WR.
  - RD: mem_read=1. Counter decrements each cycle. In the cycle the counter is 0, capture mem_outdata into rsp_rdata at the clock edge. Go to RESP.
  - WR: mem_write=1 and mem_indata valid. When the counter is 0, go to HOLD.
  - HOLD: one cycle. mem_write=0; mem_adress and mem_indata unchanged. Go to RESP.
  - RESP: rsp_valid=1 for exactly one cycle; req_ready=0. Go to IDLE.
- req_ready is 1 only in IDLE. Requests presented in any other state wait; the requester holds req_* stable until accepted.
- Latency, counted from the accepting edge to the cycle with rsp_valid high:
  - read: RD_WAIT+2 cycles.
  - write: WR_CYCLES+3 cycles.
- Throughput: at most one transaction per latency+1 cycles (return through IDLE).
- Signal stability:
  - mem_adress and mem_indata change only on the accepting edge, and hold between transactions.
  - rsp_rdata is not modified by writes.
- Invariants:
  - mem_read and mem_write are never high in the same cycle.
  - Neither is high in IDLE, SETUP, HOLD or RESP.
- Wait counter: 4-bit. Parameter values of 0 or above 15 are rejected at elaboration with a $error.
- Reset mid-transaction: the transaction is dropped and no rsp_valid is issued. mem_read and mem_write drop asynchronously with rst_n.
- Address 12'hFFF and data 16'hFFFF are ordinary values; there is no wrap-around behaviour in the block.

Decomposition:
- Shared package basic_pkg:
  - ADDR_W=12, DATA_W=16 constants.
  - mem_state_t enum {IDLE, SETUP, RD, WR, HOLD, RESP}.
  - This package is shared with the memory and the control unit.
- One sub-module, mem_wait_cnt: a 4-bit loadable down-counter with load, value and zero-flag.
- Everything else stays inline.

Test Plan:
- Reset: with rst_n=0, outputs are 0 and req_ready=0. After release, req_ready=1, mem_read=0, mem_write=0.
- Write then read: write 12'h0A5 <- 16'h1234. Check mem_write is high for exactly WR_CYCLES cycles with mem_adress=12'h0A5 from SETUP through HOLD. Then read 12'h0A5: rsp_rdata=16'h1234 with rsp_valid high at RD_WAIT+2 cycles after acceptance.
- Boundary values: write 12'hFFF <- 16'hFFFF and 12'h000 <- 16'h0000, then read both back. rsp_rdata must be 16'hFFFF and 16'h0000 respectively.
- Back-to-back: hold req_valid high for a read followed by a write.
  - req_ready is low from the accepting edge until IDLE.
  - The second request is accepted exactly one cycle after RESP.
  - The write leaves rsp_rdata unchanged.
- Reset mid-operation: assert rst_n=0 during RD with RD_WAIT=4.
  - mem_read=0 immediately, with no rsp_valid.
  - After release, a new read of a previously written address returns the correct data.
- Invariant checks, run continuously across a randomized run of 1000 mixed requests:
  - Assertion: mem_read and mem_write are never both high.
  - Assertion: mem_adress changes only on an accepting edge.
  - Every read returns the last value written to that address, checked against a scoreboard.
